skid_rev: RTL and testbench

//  Backward-registered valid/ready slice (skid buffer). Cuts the combinational rdy_b->rdy_a path
//  in the ready direction. Data/valid pass through with zero latency. A one-entry skid register

---
 rtl/skid_rev.sv | 85 ++++++++
 tb/tb_skid_rev.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/skid_rev.sv
// rtl/skid_rev.sv - backward-registered valid/ready skid slice with stall/drop counters
// rdy_a comes straight from a flop; a single skid register holds the beat in flight on a stall.
module skid_rev #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_a,
  input  logic             vld_a,
  output logic             rdy_a,
  output logic [WIDTH-1:0] data_b,
  output logic             vld_b,
  input  logic             rdy_b,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {EMPTY = 1'b0, SKID = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             rdy_nxt;
  logic             capture;
  logic             stall_inc;
  logic             drop_inc;
  logic             gnt_a;
  logic [WIDTH-1:0] skid_data;

  assign gnt_a = vld_a & rdy_a;

  always_comb begin
    state_nxt = state;
    rdy_nxt   = 1'b1;
    capture   = 1'b0;
    stall_inc = 1'b0;
    drop_inc  = 1'b0;
    vld_b     = 1'b0;
    data_b    = data_a;
    case (state)
      EMPTY: begin
        vld_b = gnt_a & ~flush;
        if (gnt_a & flush) begin
          drop_inc = 1'b1;
        end else if (gnt_a & ~rdy_b) begin
          capture   = 1'b1;
          state_nxt = SKID;
          rdy_nxt   = 1'b0;
        end
      end
      SKID: begin
        // flush outranks the downstream grant: the held beat never leaves
        vld_b  = ~flush;
        data_b = skid_data;
        if (flush) begin
          drop_inc  = 1'b1;
          state_nxt = EMPTY;
        end else if (rdy_b) begin
          state_nxt = EMPTY;
        end else begin
          stall_inc = 1'b1;
          rdy_nxt   = 1'b0;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      rdy_a     <= 1'b0;
      skid_data <= '0;
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      state <= state_nxt;
      rdy_a <= rdy_nxt;
      if (capture) skid_data <= data_a;
      if (stall_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (drop_inc && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_skid_rev.sv
// tb/tb_skid_rev.sv - vector table, one-entry queue reference model and random scoreboard for skid_rev
module tb_skid_rev;

  logic        clk = 1'b0;
  logic        rst, vld_a, rdy_b, flush;
  logic [31:0] data_a;
  logic        rdy_a, vld_b;
  logic [31:0] data_b;
  logic [15:0] stall_cnt, drop_cnt;
  logic        s_rdy_a, s_vld_b;
  logic [31:0] s_data_b;
  logic [3:0]  s_stall, s_drop;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  skid_rev #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .data_a(data_a), .vld_a(vld_a), .rdy_a(rdy_a),
    .data_b(data_b), .vld_b(vld_b), .rdy_b(rdy_b), .flush(flush),
    .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
  );

  skid_rev #(.WIDTH(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .data_a(data_a), .vld_a(vld_a), .rdy_a(s_rdy_a),
    .data_b(s_data_b), .vld_b(s_vld_b), .rdy_b(rdy_b), .flush(flush),
    .stall_cnt(s_stall), .drop_cnt(s_drop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the slice is a queue holding at most one beat
  int q[$];
  bit m_en = 0;
  bit m_just_rst = 0;
  int m_stall = 0;
  int m_drop = 0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_stall = 0;
      m_drop = 0;
      m_just_rst = 1;
      m_en = 1;
    end else if (m_en) begin
      bit can_take;
      can_take = (q.size() == 0) && !m_just_rst;
      m_just_rst = 0;
      if (q.size() != 0) begin
        if (flush) begin
          void'(q.pop_front());
          m_drop++;
        end else if (rdy_b) begin
          void'(q.pop_front());
        end else begin
          m_stall++;
        end
      end else if (vld_a && can_take) begin
        if (flush) m_drop++;
        else if (!rdy_b) q.push_back(int'(data_a));
      end
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      logic e_rdy, e_vld;
      logic [31:0] e_dat;
      e_rdy = (q.size() == 0) && !m_just_rst;
      if (q.size() != 0) begin
        e_vld = !flush;
        e_dat = q[0];
      end else begin
        e_vld = vld_a && e_rdy && !flush;
        e_dat = data_a;
      end
      chk("model_rdy_a", {31'b0, rdy_a}, {31'b0, e_rdy});
      chk("model_vld_b", {31'b0, vld_b}, {31'b0, e_vld});
      if (e_vld) chk("model_data_b", data_b, e_dat);
      chk("model_stall", {16'b0, stall_cnt}, sat16(m_stall));
      chk("model_drop", {16'b0, drop_cnt}, sat16(m_drop));
    end
  end

  typedef struct {
    logic        rst, vld, rdyb, fl;
    logic [31:0] din;
    logic        erdy, evld;
    logic [31:0] edat;
    int          est, edr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [31:0] d, input logic rb, input logic f,
                     input logic er, input logic ev, input logic [31:0] ed, input int es, input int edr);
    vec_t t;
    t.rst = r; t.vld = v; t.din = d; t.rdyb = rb; t.fl = f;
    t.erdy = er; t.evld = ev; t.edat = ed; t.est = es; t.edr = edr;
    tbl.push_back(t);
  endtask

  int sent[$];
  int next_data;
  int accepted;
  int cycles;

  initial begin
    rst = 1'b1; vld_a = 1'b0; data_a = '0; rdy_b = 1'b0; flush = 1'b0;

    //   rst vld data      rdyb fl | rdy vld data      stall drop
    add(1, 1, 32'h11, 1, 0,   0, 0, 32'h0,  0, 0);
    add(0, 1, 32'h11, 1, 0,   0, 0, 32'h0,  0, 0);
    for (int i = 1; i <= 8; i++) add(0, 1, i, 1, 0,   1, 1, i, 0, 0);
    add(0, 1, 32'hA5, 0, 0,   1, 1, 32'hA5, 0, 0);
    add(0, 1, 32'h77, 0, 0,   0, 1, 32'hA5, 0, 0);
    add(0, 1, 32'h77, 0, 0,   0, 1, 32'hA5, 1, 0);
    add(0, 1, 32'h77, 0, 0,   0, 1, 32'hA5, 2, 0);
    add(0, 1, 32'h77, 1, 0,   0, 1, 32'hA5, 3, 0);
    add(0, 1, 32'h77, 1, 0,   1, 1, 32'h77, 3, 0);
    add(0, 1, 32'h55, 0, 0,   1, 1, 32'h55, 3, 0);
    add(0, 0, 32'h0,  0, 1,   0, 0, 32'h0,  3, 0);
    add(0, 0, 32'h0,  1, 0,   1, 0, 32'h0,  3, 1);
    add(0, 1, 32'h66, 1, 1,   1, 0, 32'h0,  3, 1);
    add(0, 0, 32'h0,  1, 0,   1, 0, 32'h0,  3, 2);
    add(0, 1, 32'h99, 0, 0,   1, 1, 32'h99, 3, 2);
    add(0, 0, 32'h0,  0, 0,   0, 1, 32'h99, 3, 2);
    add(1, 0, 32'h0,  0, 0,   0, 1, 32'h99, 4, 2);
    add(0, 1, 32'h42, 1, 0,   0, 0, 32'h0,  0, 0);
    add(0, 1, 32'h43, 1, 0,   1, 1, 32'h43, 0, 0);

    @(posedge clk);
    foreach (tbl[i]) begin
      #1;
      rst = tbl[i].rst; vld_a = tbl[i].vld; data_a = tbl[i].din;
      rdy_b = tbl[i].rdyb; flush = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy_a", i), {31'b0, rdy_a}, {31'b0, tbl[i].erdy});
      chk($sformatf("tbl%0d_vld_b", i), {31'b0, vld_b}, {31'b0, tbl[i].evld});
      if (tbl[i].evld) chk($sformatf("tbl%0d_data_b", i), data_b, tbl[i].edat);
      chk($sformatf("tbl%0d_stall", i), {16'b0, stall_cnt}, tbl[i].est);
      chk($sformatf("tbl%0d_drop", i), {16'b0, drop_cnt}, tbl[i].edr);
      @(posedge clk);
    end

    // Saturation: capture 0x5A and stall 20 cycles; the 4-bit counter must stop at 15
    #1; vld_a = 1'b1; data_a = 32'h5A; rdy_b = 1'b0;
    @(posedge clk); #1; vld_a = 1'b0;
    repeat (20) @(posedge clk);
    #1; rdy_b = 1'b1;
    @(negedge clk);
    chk("sat_small_stall", {28'b0, s_stall}, 32'd15);
    chk("sat_main_stall", {16'b0, stall_cnt}, 32'd20);
    chk("sat_small_vld", {31'b0, s_vld_b}, 32'd1);
    chk("sat_small_data", s_data_b, 32'h5A);

    // Random downstream ready, 1000 beats with incrementing payload
    next_data = 32'h1000;
    accepted = 0;
    cycles = 0;
    while (accepted < 1000 && cycles < 20000) begin
      @(posedge clk); #1;
      vld_a = ($urandom_range(0, 3) != 0);
      data_a = next_data;
      rdy_b = $urandom_range(0, 1);
      @(negedge clk);
      cycles++;
      if (vld_a && rdy_a) begin
        sent.push_back(next_data);
        next_data++;
        accepted++;
      end
      if (vld_b && rdy_b) begin
        if (sent.size() == 0) begin
          vectors++; errors++;
          $display("FAIL sb_extra: got %h expected no beat", data_b);
        end else begin
          chk("sb_order", data_b, sent.pop_front());
        end
      end
    end
    chk("sb_budget", accepted, 1000);

    @(posedge clk); #1; vld_a = 1'b0; rdy_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (vld_b && rdy_b) begin
        if (sent.size() == 0) begin
          vectors++; errors++;
          $display("FAIL sb_extra: got %h expected no beat", data_b);
        end else begin
          chk("sb_order", data_b, sent.pop_front());
        end
      end
      @(posedge clk); #1;
    end
    chk("sb_lost", sent.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
